// File: rtl/bcd_to_unsigned.sv
// Sequential reverse double-dabble: converts a packed BCD word to unsigned binary,
// one shift or subtract-3 step per clock, with a fixed 63-cycle busy time for 8 digits.
module bcd_to_unsigned #(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  output logic [OUT_W-1:0]      bin
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB3  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   dreg;
  logic [BW-1:0]   breg;
  logic [5:0]      counter;
  logic            inv;

  logic [2*BW-1:0] work_shift;
  logic [BW-1:0]   dreg_sub3;
  logic            bcd_invalid;
  logic            last_shift;
  logic [OUT_W-1:0] bin_next;

  assign work_shift = {dreg, breg} >> 1;
  assign last_shift = (counter == 6'(BW));
  assign bin_next   = OUT_W'(work_shift[BW-1:0]);
  assign idle       = (state == S_IDLE);

  // Columns are independent 4-bit lanes; a column >= 8 borrowed a 10 from above.
  always_comb begin
    dreg_sub3 = dreg;
    for (int i = 0; i < DIGITS; i++) begin
      if (dreg[4*i+3]) dreg_sub3[4*i +: 4] = dreg[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bcd_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bcd_invalid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = trigger ? S_SHIFT : S_IDLE;
      S_SHIFT: state_next = last_shift ? S_IDLE : S_SUB3;
      S_SUB3:  state_next = S_SHIFT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dreg    <= '0;
      breg    <= '0;
      counter <= '0;
      inv     <= 1'b0;
      bin     <= '0;
      error   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            dreg    <= bcd;
            breg    <= '0;
            counter <= 6'd1;
            inv     <= bcd_invalid;
          end
        end
        S_SHIFT: begin
          {dreg, breg} <= work_shift;
          if (last_shift) begin
            bin   <= inv ? '0 : bin_next;
            error <= inv;
            done  <= 1'b1;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        S_SUB3: dreg <= dreg_sub3;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Bench for bcd_to_unsigned: directed cases from the feature list plus random
// BCD words checked against a digit-by-digit decimal reference model.
module tb_bcd_to_unsigned;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic [31:0] bcd;
  logic        idle;
  logic        done;
  logic        error;
  logic [31:0] bin;

  int checks;
  int failures;

  bcd_to_unsigned #(.DIGITS(8), .OUT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .done    (done),
    .error   (error),
    .bin     (bin)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: plain decimal accumulation over the digits
  function automatic logic [31:0] ref_value(input logic [31:0] b, output logic bad);
    logic [31:0] v;
    int d;
    v   = 0;
    bad = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 32'hF);
      if (d > 9) bad = 1'b1;
      v = v * 10 + 32'(d);
    end
    return bad ? 32'd0 : v;
  endfunction

  // driver: one conversion, checks latency, busy flag, result and one-cycle done
  task automatic run_conv(input string tag, input logic [31:0] v,
                          input logic [31:0] exp_bin, input logic exp_err);
    int   lat;
    logic busy_ok;
    bcd     = v;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    bcd     = $urandom;
    busy_ok = !idle && !done;
    lat     = 0;
    do begin
      step();
      lat++;
      if (!done && idle) busy_ok = 1'b0;
    end while (!done && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'd63);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    check({tag, "_bin"}, bin, exp_bin);
    check({tag, "_err"}, {31'd0, error}, {31'd0, exp_err});
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_bin_hold"}, bin, exp_bin);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_v;
    logic        exp_bad;
    logic        busy_ok;
    int          n_done;
    int          last_t;
    int          t;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    trigger  = 1'b0;
    bcd      = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    check("rst_bin", bin, 32'd0);

    run_conv("zero", 32'h00000000, 32'h00000000, 1'b0);
    run_conv("c42", 32'h00000042, 32'h0000002A, 1'b0);
    run_conv("c12345678", 32'h12345678, 32'h00BC614E, 1'b0);
    run_conv("cmax", 32'h99999999, 32'h05F5E0FF, 1'b0);
    run_conv("invalid", 32'h0000001A, 32'h00000000, 1'b1);
    run_conv("after_inv", 32'h00000010, 32'h0000000A, 1'b0);

    // trigger while busy is ignored and bcd changes do not leak in
    bcd     = 32'h00000555;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    busy_ok = 1'b1;
    n_done  = 0;
    for (int i = 1; i <= 62; i++) begin
      if (i == 10) begin
        bcd     = 32'h00000999;
        trigger = 1'b1;
      end
      step();
      trigger = 1'b0;
      if (idle) busy_ok = 1'b0;
      if (done) n_done++;
    end
    check("busy_trig_idle", {31'd0, busy_ok}, 32'd1);
    step();
    check("busy_trig_done", {31'd0, done}, 32'd1);
    check("busy_trig_bin", bin, 32'h0000022B);
    for (int i = 0; i < 80; i++) begin
      step();
      if (done) n_done++;
    end
    check("busy_trig_single", 32'(n_done), 32'd0);

    // reset mid-conversion discards the work
    bcd     = 32'h87654321;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 1; i < 20; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_idle", {31'd0, idle}, 32'd1);
    check("midrst_bin", bin, 32'd0);
    check("midrst_err", {31'd0, error}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_conv("after_rst", 32'h00000007, 32'h00000007, 1'b0);

    // random words, mostly valid digits, some with a digit above 9
    for (int n = 0; n < 24; n++) begin
      v = '0;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
        else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if (n < 16) v = {v[31:4] & 28'h6666666, v[3:0] > 4'd9 ? 4'd3 : v[3:0]};
      exp_v = ref_value(v, exp_bad);
      run_conv($sformatf("rand%0d_%h", n, v), v, exp_v, exp_bad);
    end

    // trigger held high: completions every 64 cycles
    bcd     = 32'h00000100;
    trigger = 1'b1;
    n_done  = 0;
    last_t  = 0;
    t       = 0;
    while (n_done < 4 && t < 400) begin
      step();
      t++;
      if (done) begin
        check($sformatf("hold_bin%0d", n_done), bin, 32'h00000064);
        if (n_done > 0) check($sformatf("hold_period%0d", n_done), 32'(t - last_t), 32'd64);
        last_t = t;
        n_done++;
      end
    end
    trigger = 1'b0;
    check("hold_count", 32'(n_done), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
